// File: rtl/lcd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_bus_arbiter
//   Owns the 8-bit parallel bus of an HD44780-style LCD1602. After reset it waits
//   for the panel to power up and writes the six-byte init sequence. It then
//   shares the bus round-robin between two requesters, one transfer at a time.
//   Each transfer runs SETUP -> EN_HI -> HOLD -> WAIT, and the busy wait is longer
//   for clear/home commands. Requesters see only a req/ack handshake.
//
// Ports
//   clock_50mhz          system clock, rising edge
//   rst_n                asynchronous active-low reset
//   req0/rs0/data0       requester 0 level request, register select, byte
//   ack0                 one-cycle pulse, requester 0 transfer accepted
//   req1/rs1/data1/ack1  same for requester 1
//   init_done            high once the init sequence has completed
//   busy                 high whenever the arbiter is not in ARB
//   rs_pin/rw_pin/en_pin LCD RS, RW (always 0), E
//   pinLCD               LCD D7..D0
// -----------------------------------------------------------------------------
module lcd_bus_arbiter #(
   parameter int unsigned T_SETUP   = 50,
   parameter int unsigned T_EN      = 50,
   parameter int unsigned T_HOLD    = 50,
   parameter int unsigned T_CMD     = 2500,
   parameter int unsigned T_CLR     = 100000,
   parameter int unsigned T_POWERUP = 2000000
) (
   input  logic       clock_50mhz,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       rs0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic       rs1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       init_done,
   output logic       busy,
   output logic       rs_pin,
   output logic       rw_pin,
   output logic       en_pin,
   output logic [7:0] pinLCD
);

   typedef enum logic [2:0] {PWR_WAIT, ARB, SETUP, EN_HI, HOLD, WAIT} state_t;

   // Timer load values: a phase of N cycles loads N-1 and ends on the cycle the
   // timer reads 0.
   localparam logic [20:0] LD_SETUP  = 21'(T_SETUP - 1);
   localparam logic [20:0] LD_EN     = 21'(T_EN - 1);
   localparam logic [20:0] LD_HOLD   = 21'(T_HOLD - 1);
   localparam logic [20:0] LD_CMD    = 21'(T_CMD - 1);
   localparam logic [20:0] LD_CLR    = 21'(T_CLR - 1);
   localparam logic [20:0] PWR_LAST  = 21'(T_POWERUP - 1);
   localparam logic [2:0]  INIT_LAST = 3'd5;

   state_t      state_q, state_d;
   logic [20:0] timer_q, timer_d;
   logic [2:0]  idx_q, idx_d;
   logic        rr_q, rr_d;          // last granted requester
   logic        done_q, done_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic        en_q, en_d;
   logic        grant1;

   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_byte = 8'h30;
         3'd3:             init_byte = 8'h38;
         3'd4:             init_byte = 8'h01;
         default:          init_byte = 8'h0C;
      endcase
   endfunction

   // Clear display (01) and return home (02/03) need the long busy wait.
   function automatic logic [20:0] wait_load(input logic rs, input logic [7:0] d);
      wait_load = (!rs && d[7:2] == 6'd0) ? LD_CLR : LD_CMD;
   endfunction

   // Both pending: serve the one not granted last. Reset value rr=1 lets 0 win.
   assign grant1 = req1 & (~req0 | ~rr_q);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      rr_d    = rr_q;
      done_d  = done_q;
      rs_d    = rs_q;
      data_d  = data_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      case (state_q)
         // Power-up wait counts up from the reset value 0; every other phase
         // counts down to 0.
         PWR_WAIT: begin
            if (timer_q == PWR_LAST) begin
               state_d = SETUP;
               timer_d = LD_SETUP;
               idx_d   = 3'd0;
               rs_d    = 1'b0;
               data_d  = init_byte(3'd0);
            end else begin
               timer_d = timer_q + 21'd1;
            end
         end
         ARB: begin
            if (req0 || req1) begin
               rs_d    = grant1 ? rs1 : rs0;
               data_d  = grant1 ? data1 : data0;
               ack0_d  = ~grant1;
               ack1_d  = grant1;
               rr_d    = grant1;
               state_d = SETUP;
               timer_d = LD_SETUP;
            end
         end
         SETUP: begin
            if (timer_q == 21'd0) begin
               state_d = EN_HI;
               timer_d = LD_EN;
            end else begin
               timer_d = timer_q - 21'd1;
            end
         end
         EN_HI: begin
            if (timer_q == 21'd0) begin
               state_d = HOLD;
               timer_d = LD_HOLD;
            end else begin
               timer_d = timer_q - 21'd1;
            end
         end
         HOLD: begin
            if (timer_q == 21'd0) begin
               state_d = WAIT;
               timer_d = wait_load(rs_q, data_q);
            end else begin
               timer_d = timer_q - 21'd1;
            end
         end
         WAIT: begin
            if (timer_q != 21'd0) begin
               timer_d = timer_q - 21'd1;
            end else if (!done_q && idx_q != INIT_LAST) begin
               idx_d   = idx_q + 3'd1;
               rs_d    = 1'b0;
               data_d  = init_byte(idx_q + 3'd1);
               state_d = SETUP;
               timer_d = LD_SETUP;
            end else begin
               done_d  = 1'b1;
               state_d = ARB;
            end
         end
         default: begin
            state_d = PWR_WAIT;
            timer_d = 21'd0;
         end
      endcase
      // E is registered from the next state so it is glitch-free and high
      // exactly while the state register holds EN_HI.
      en_d = (state_d == EN_HI);
   end

   always_ff @(posedge clock_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PWR_WAIT;
         timer_q <= 21'd0;
         idx_q   <= 3'd0;
         rr_q    <= 1'b1;
         done_q  <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         done_q  <= done_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         en_q    <= en_d;
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign init_done = done_q;
   assign busy      = (state_q != ARB);
   assign rs_pin    = rs_q;
   assign rw_pin    = 1'b0;
   assign en_pin    = en_q;
   assign pinLCD    = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
module tb_lcd_bus_arbiter;

   localparam int T_SETUP   = 3;
   localparam int T_EN      = 4;
   localparam int T_HOLD    = 2;
   localparam int T_CMD     = 20;
   localparam int T_CLR     = 200;
   localparam int T_POWERUP = 100;
   localparam int LIMIT     = 4000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, rs0, req1, rs1;
   logic [7:0] data0, data1;
   logic       ack0, ack1, init_done, busy, rs_pin, rw_pin, en_pin;
   logic [7:0] pinLCD;

   always #5 clk = ~clk;

   lcd_bus_arbiter #(
      .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
      .T_CMD(T_CMD), .T_CLR(T_CLR), .T_POWERUP(T_POWERUP)
   ) dut (
      .clock_50mhz(clk), .rst_n(rst_n),
      .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
      .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
      .init_done(init_done), .busy(busy),
      .rs_pin(rs_pin), .rw_pin(rw_pin), .en_pin(en_pin), .pinLCD(pinLCD)
   );

   typedef struct {
      int         who;   // 0/1 requester, 2 = init byte
      logic       rs;
      logic [7:0] data;
   } xfer_t;

   xfer_t sb[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   int    last_grant;

   // monitor state
   int    cyc, ack_cyc, rise_cyc, fall_cyc, arb_cyc, prev_wait, last_who;
   bit    first_en, have_cur, en_prev, busy_prev, ack_prev;
   xfer_t cur;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_wait(input logic rs, input logic [7:0] d);
      return (!rs && d[7:2] == 6'd0) ? T_CLR : T_CMD;
   endfunction

   function automatic void push(input int who, input logic rs, input logic [7:0] d);
      xfer_t e;
      e.who = who; e.rs = rs; e.data = d;
      sb.push_back(e);
      if (who != 2) last_grant = who;
   endfunction

   task automatic push_init();
      logic [7:0] ib [6];
      ib = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h01, 8'h0C};
      for (int i = 0; i < 6; i++) push(2, 1'b0, ib[i]);
      last_grant = 1;
   endtask

   task automatic wait_ack(input int who);
      int  n;
      bit  seen;
      n = 0;
      seen = 0;
      while (!seen && n < LIMIT) begin
         @(negedge clk);
         n++;
         seen = (who == 0) ? ack0 : ack1;
      end
      check($sformatf("ack%0d_seen", who), seen, 1'b1);
   endtask

   task automatic send(input int who, input logic rs, input logic [7:0] d);
      if (who == 0) begin rs0 = rs; data0 = d; req0 = 1'b1; end
      else          begin rs1 = rs; data1 = d; req1 = 1'b1; end
      push(who, rs, d);
      wait_ack(who);
      if (who == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   // Monitor: compares each en pulse against the scoreboard and checks timing.
   initial begin : mon
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cyc = 0; first_en = 1; have_cur = 0; en_prev = 0;
            busy_prev = 1; ack_prev = 0; last_who = 2; ack_cyc = 0;
            rise_cyc = 0; fall_cyc = 0; arb_cyc = 0; prev_wait = 0;
         end else begin
            cyc++;
            if (ack0 || ack1) begin
               check("ack_exclusive", ack0 & ack1, 1'b0);
               check("ack_one_cycle", ack_prev, 1'b0);
               check("ack_after_arb", busy_prev, 1'b0);
               ack_cyc  = cyc;
               last_who = ack1 ? 1 : 0;
            end
            if (en_pin && !en_prev) begin
               rise_cyc = cyc;
               check("sb_nonempty", sb.size() != 0, 1'b1);
               if (sb.size() != 0) begin
                  cur = sb.pop_front();
                  have_cur = 1;
                  check("rs_pin", rs_pin, cur.rs);
                  check("pinLCD", pinLCD, cur.data);
                  check("rw_pin", rw_pin, 1'b0);
                  check("grant_id", last_who, cur.who);
                  if (cur.who == 2) begin
                     check("init_done_low", init_done, 1'b0);
                     if (first_en) check("powerup_time", cyc, T_POWERUP + T_SETUP);
                     else check("init_gap", cyc - fall_cyc, T_HOLD + prev_wait + T_SETUP);
                  end else begin
                     check("arb_to_en", cyc - (ack_cyc - 1), 1 + T_SETUP);
                  end
               end
               first_en = 0;
               last_who = 2;
            end
            if (!en_pin && en_prev) begin
               check("en_width", cyc - rise_cyc, T_EN);
               fall_cyc  = cyc;
               prev_wait = exp_wait(cur.rs, cur.data);
            end
            if (!busy && busy_prev) begin
               arb_cyc = cyc;
               if (have_cur) begin
                  if (cur.who == 2) begin
                     check("init_done_high", init_done, 1'b1);
                     check("init_last_wait", cyc - fall_cyc, T_HOLD + prev_wait);
                  end else begin
                     check("arb_to_arb", cyc - (ack_cyc - 1),
                           1 + T_SETUP + T_EN + T_HOLD + prev_wait);
                  end
                  have_cur = 0;
               end
            end
            en_prev   = en_pin;
            busy_prev = busy;
            ack_prev  = ack0 | ack1;
         end
      end
   end

   initial begin : drv
      int n0, n1, k;
      int first;
      rst_n = 1'b0;
      req0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
      req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
      last_grant = 1;
      #1;
      check("rst_busy", busy, 1'b1);
      check("rst_en", en_pin, 1'b0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_pinLCD", pinLCD, 8'h00);
      check("rst_rs_pin", rs_pin, 1'b0);
      check("rst_acks", {ack0, ack1}, 2'b00);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      push_init();

      // request held during init: acked only after init, on the first ARB cycle
      rs0 = 1'b1; data0 = 8'h55; req0 = 1'b1;
      push(0, 1'b1, 8'h55);
      wait_ack(0);
      #1;
      check("ack_after_init", init_done, 1'b1);
      check("ack_first_arb", ack_cyc - arb_cyc, 1);
      req0 = 1'b0;

      // single data write
      send(0, 1'b1, 8'h41);

      // clear command followed by data: long wait after 01
      send(1, 1'b0, 8'h01);
      send(0, 1'b1, 8'h30);

      // both requesters held: grants alternate
      first = (last_grant == 0) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         if ((i % 2 == 0) == (first == 1)) push(1, 1'b1, 8'h42);
         else                              push(0, 1'b1, 8'h41);
      end
      rs0 = 1'b1; data0 = 8'h41; req0 = 1'b1;
      rs1 = 1'b1; data1 = 8'h42; req1 = 1'b1;
      n0 = 0; n1 = 0; k = 0;
      while ((n0 < 2 || n1 < 2) && k < 4 * LIMIT) begin
         @(negedge clk);
         k++;
         if (ack0) begin n0++; if (n0 == 2) req0 = 1'b0; end
         if (ack1) begin n1++; if (n1 == 2) req1 = 1'b0; end
      end
      check("rr_ack0_count", n0, 2);
      check("rr_ack1_count", n1, 2);

      // reset while en is high
      send(1, 1'b1, 8'h43);
      k = 0;
      while (!en_pin && k < 100) begin @(negedge clk); k++; end
      check("en_before_abort", en_pin, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_en", en_pin, 1'b0);
      check("abort_acks", {ack0, ack1}, 2'b00);
      check("abort_init_done", init_done, 1'b0);
      check("abort_busy", busy, 1'b1);
      sb.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      push_init();
      k = 0;
      while (!init_done && k < LIMIT) begin @(negedge clk); k++; end
      check("reinit_done", init_done, 1'b1);
      send(1, 1'b1, 8'h5A);

      k = 0;
      while ((sb.size() != 0 || have_cur) && k < LIMIT) begin @(negedge clk); k++; end
      check("sb_drained", sb.size(), 0);
      check("last_done", have_cur, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
